// File: rtl/debounce_scan_controller.sv
// Time-multiplexed switch debouncer: one shared evaluation datapath visits one
// channel per sample strobe, keeping only a debounced bit and stability count per channel.
module debounce_scan_controller #(
    parameter int unsigned NUM_SWITCHES = 4,
    parameter int unsigned SAMPLE_DIV   = 2500,
    parameter int unsigned STABLE_COUNT = 25
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_L,
    input  logic                            i_Enable,
    input  logic [NUM_SWITCHES-1:0]         i_Switch,
    output logic [NUM_SWITCHES-1:0]         o_Debounced,
    output logic [NUM_SWITCHES-1:0]         o_Press,
    output logic [NUM_SWITCHES-1:0]         o_Release,
    output logic [$clog2(NUM_SWITCHES)-1:0] o_Scan_Index
);

    localparam int unsigned IW = $clog2(NUM_SWITCHES);
    localparam int unsigned DW = $clog2(SAMPLE_DIV);
    localparam int unsigned CW = $clog2(STABLE_COUNT + 1);

    typedef enum logic {
        ST_WAIT,
        ST_EVAL
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SWITCHES-1:0] sync1_q, sync2_q;
    logic [NUM_SWITCHES-1:0] deb_q, deb_d;
    logic [NUM_SWITCHES-1:0] press_q, press_d;
    logic [NUM_SWITCHES-1:0] rel_q, rel_d;
    logic [DW-1:0]           div_q, div_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           cnt_q [NUM_SWITCHES];
    logic [CW-1:0]           cnt_d [NUM_SWITCHES];
    logic                    strobe;

    always_comb begin
        strobe  = i_Enable && (div_q == DW'(SAMPLE_DIV - 1));
        div_d   = div_q;
        if (i_Enable) begin
            div_d = strobe ? '0 : div_q + 1'b1;
        end
        state_d = state_q;
        ptr_d   = ptr_q;
        deb_d   = deb_q;
        press_d = '0;
        rel_d   = '0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (strobe) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // EVAL is never gated by i_Enable so a visit always completes
                state_d = ST_WAIT;
                ptr_d   = (ptr_q == IW'(NUM_SWITCHES - 1)) ? '0 : ptr_q + 1'b1;
                if (sync2_q[ptr_q] == deb_q[ptr_q]) begin
                    cnt_d[ptr_q] = '0;
                end else if (cnt_q[ptr_q] == CW'(STABLE_COUNT - 1)) begin
                    cnt_d[ptr_q] = '0;
                    deb_d[ptr_q] = sync2_q[ptr_q];
                    if (sync2_q[ptr_q]) begin
                        press_d[ptr_q] = 1'b1;
                    end else begin
                        rel_d[ptr_q] = 1'b1;
                    end
                end else begin
                    cnt_d[ptr_q] = cnt_q[ptr_q] + 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_WAIT;
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            div_q   <= '0;
            ptr_q   <= '0;
            for (int unsigned k = 0; k < NUM_SWITCHES; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            div_q   <= div_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Debounced  = deb_q;
    assign o_Press      = press_q;
    assign o_Release    = rel_q;
    assign o_Scan_Index = ptr_q;

endmodule

// File: tb/tb_debounce_scan_controller.sv
// Directed bench for debounce_scan_controller with NUM_SWITCHES=4, SAMPLE_DIV=4, STABLE_COUNT=3.
module tb_debounce_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] sw;
    logic [3:0] deb, press, rel;
    logic [1:0] idx;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    debounce_scan_controller #(
        .NUM_SWITCHES(4),
        .SAMPLE_DIV  (4),
        .STABLE_COUNT(3)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Enable    (en),
        .i_Switch    (sw),
        .o_Debounced (deb),
        .o_Press     (press),
        .o_Release   (rel),
        .o_Scan_Index(idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Edge 1 is the first rising edge after reset release.
    task automatic start(input logic [3:0] s);
        sw    = s;
        en    = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        sw = 4'b1111;
        en = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({deb, press, rel, idx} !== 14'd0) begin
            errors++;
            $display("FAIL reset_async: deb=%b press=%b rel=%b idx=%0d, expected all 0", deb, press, rel, idx);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({deb, press, rel, idx} !== 14'd0) begin
            errors++;
            $display("FAIL reset_hold: deb=%b press=%b rel=%b idx=%0d, expected all 0", deb, press, rel, idx);
        end
    endtask

    task automatic test_steady_press();
        logic [3:0] ed, ep;
        start(4'b0100);
        for (int n = 1; n <= 60; n++) begin
            step();
            ed = (n >= 45) ? 4'b0100 : 4'b0000;
            ep = (n == 45) ? 4'b0100 : 4'b0000;
            checks++;
            if (deb !== ed || press !== ep || rel !== 4'b0000) begin
                errors++;
                $display("FAIL steady_press edge %0d: deb=%b press=%b rel=%b, expected %b %b 0000", n, deb, press, rel, ed, ep);
            end
            if (n == 4 || n == 12) begin
                checks++;
                if (idx !== ((n == 4) ? 2'd0 : 2'd2)) begin
                    errors++;
                    $display("FAIL scan_index edge %0d: got %0d, expected %0d", n, idx, (n == 4) ? 0 : 2);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] ed, ep;
        start(4'b0010);
        for (int n = 1; n <= 95; n++) begin
            step();
            if (n == 30) sw = 4'b0000;
            if (n == 46) sw = 4'b0010;
            ed = (n >= 89) ? 4'b0010 : 4'b0000;
            ep = (n == 89) ? 4'b0010 : 4'b0000;
            checks++;
            if (deb !== ed || press !== ep || rel !== 4'b0000) begin
                errors++;
                $display("FAIL bounce edge %0d: deb=%b press=%b rel=%b, expected %b %b 0000", n, deb, press, rel, ed, ep);
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] ed, ep, er;
        start(4'b0100);
        for (int n = 1; n <= 100; n++) begin
            step();
            if (n == 46) sw = 4'b0000;
            ed = (n >= 45 && n < 93) ? 4'b0100 : 4'b0000;
            ep = (n == 45) ? 4'b0100 : 4'b0000;
            er = (n == 93) ? 4'b0100 : 4'b0000;
            checks++;
            if (deb !== ed || press !== ep || rel !== er) begin
                errors++;
                $display("FAIL release edge %0d: deb=%b press=%b rel=%b, expected %b %b %b", n, deb, press, rel, ed, ep, er);
            end
        end
    endtask

    task automatic test_all_rise();
        logic [3:0] ed, ep;
        start(4'b0000);
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == 1) sw = 4'b1111;
            for (int c = 0; c < 4; c++) begin
                ed[c] = (n >= 37 + 4 * c);
                ep[c] = (n == 37 + 4 * c);
            end
            checks++;
            if (deb !== ed || press !== ep || rel !== 4'b0000) begin
                errors++;
                $display("FAIL all_rise edge %0d: deb=%b press=%b rel=%b, expected %b %b 0000", n, deb, press, rel, ed, ep);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [3:0] ed, ep;
        start(4'b0001);
        for (int n = 1; n <= 70; n++) begin
            step();
            if (n == 22) en = 1'b0;
            if (n == 42) en = 1'b1;
            ed = (n >= 57) ? 4'b0001 : 4'b0000;
            ep = (n == 57) ? 4'b0001 : 4'b0000;
            checks++;
            if (deb !== ed || press !== ep || rel !== 4'b0000) begin
                errors++;
                $display("FAIL enable_freeze edge %0d: deb=%b press=%b rel=%b, expected %b %b 0000", n, deb, press, rel, ed, ep);
            end
            if (n >= 23 && n <= 43) begin
                checks++;
                if (idx !== 2'd1) begin
                    errors++;
                    $display("FAIL freeze_index edge %0d: got %0d, expected 1", n, idx);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] ed, ep;
        start(4'b0011);
        for (int n = 1; n <= 40; n++) step();
        checks++;
        if (deb !== 4'b0001 || idx !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset: deb=%b idx=%0d, expected 0001 1", deb, idx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({deb, press, rel, idx} !== 14'd0) begin
            errors++;
            $display("FAIL mid_eval_reset: deb=%b press=%b rel=%b idx=%0d, expected all 0", deb, press, rel, idx);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        for (int n = 1; n <= 45; n++) begin
            step();
            ed = {2'b00, (n >= 41), (n >= 37)};
            ep = {2'b00, (n == 41), (n == 37)};
            checks++;
            if (deb !== ed || press !== ep || rel !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset edge %0d: deb=%b press=%b rel=%b, expected %b %b 0000", n, deb, press, rel, ed, ep);
            end
            if (n == 4 || n == 5) begin
                checks++;
                if (idx !== ((n == 4) ? 2'd0 : 2'd1)) begin
                    errors++;
                    $display("FAIL first_strobe_index edge %0d: got %0d, expected %0d", n, idx, n - 4);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b1;
        sw    = 4'b0000;
        test_reset();
        test_steady_press();
        test_bounce();
        test_release();
        test_all_rise();
        test_enable_freeze();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
